store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 205 ++++++++++++++++++++
 tb/tb_store_buffer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of pending stores sharing one data-memory port with loads.
// Define STORE_FWD_EN to enable store-to-load forwarding; without it any overlap stalls the load.

package store_buffer_pkg;
    typedef enum logic [2:0] {
        BYTE   = 3'b000,
        HALF   = 3'b001,
        WORD   = 3'b010,
        U_BYTE = 3'b100,
        U_HALF = 3'b101
    } load3_t;
endpackage

module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        st_valid_i,
    input  logic [ADDRESS_WIDTH-1:0]    st_addr_i,
    input  logic [DATA_WIDTH*4-1:0]     st_data_i,
    input  load3_t                      st_size_i,
    output logic                        st_ready_o,
    input  logic                        ld_valid_i,
    input  logic [ADDRESS_WIDTH-1:0]    ld_addr_i,
    input  load3_t                      ld_size_i,
    output logic                        fwd_hit_o,
    output logic [DATA_WIDTH*4-1:0]     fwd_data_o,
    output logic                        fwd_stall_o,
    output logic [ADDRESS_WIDTH-1:0]    mem_a_o,
    output logic [DATA_WIDTH*4-1:0]     mem_wd_o,
    output load3_t                      mem_load3_o,
    output logic                        mem_wen_o,
    output logic [$clog2(DEPTH):0]      count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = DATA_WIDTH * 4;

    function automatic logic [2:0] size_bytes(input load3_t s);
        case (s)
            BYTE, U_BYTE: return 3'd1;
            HALF, U_HALF: return 3'd2;
            default:      return 3'd4;
        endcase
    endfunction

    function automatic load3_t store_size(input load3_t s);
        case (s)
            U_BYTE:  return BYTE;
            U_HALF:  return HALF;
            default: return s;
        endcase
    endfunction

    // Distances are taken modulo 2^ADDRESS_WIDTH so ranges wrapping past the top still overlap.
    function automatic logic ranges_overlap(
        input logic [ADDRESS_WIDTH-1:0] a_addr,
        input logic [2:0]               a_len,
        input logic [ADDRESS_WIDTH-1:0] b_addr,
        input logic [2:0]               b_len
    );
        logic [ADDRESS_WIDTH-1:0] b_from_a;
        logic [ADDRESS_WIDTH-1:0] a_from_b;
        b_from_a = b_addr - a_addr;
        a_from_b = a_addr - b_addr;
        return (b_from_a < ADDRESS_WIDTH'(a_len)) || (a_from_b < ADDRESS_WIDTH'(b_len));
    endfunction

`ifdef STORE_FWD_EN
    function automatic logic [WD_W-1:0] extend(input logic [WD_W-1:0] d, input load3_t s);
        logic [WD_W-1:0] r;
        case (s)
            BYTE:    r = {{(3*DATA_WIDTH){d[DATA_WIDTH-1]}},   d[DATA_WIDTH-1:0]};
            HALF:    r = {{(2*DATA_WIDTH){d[2*DATA_WIDTH-1]}}, d[2*DATA_WIDTH-1:0]};
            U_BYTE:  r = {{(3*DATA_WIDTH){1'b0}},              d[DATA_WIDTH-1:0]};
            U_HALF:  r = {{(2*DATA_WIDTH){1'b0}},              d[2*DATA_WIDTH-1:0]};
            default: r = d;
        endcase
        return r;
    endfunction
`endif

    logic [ADDRESS_WIDTH-1:0] r_addr [DEPTH];
    logic [WD_W-1:0]          r_data [DEPTH];
    load3_t                   r_size [DEPTH];
    logic [PTR_W-1:0]         r_head;
    logic [PTR_W-1:0]         r_tail;
    logic [CNT_W-1:0]         r_count;
    logic                     r_ready;

    logic                     w_enq;
    logic                     w_drain;
    logic                     w_load_own;
    logic [CNT_W-1:0]         w_count_next;
    logic [2:0]               w_ld_len;
    logic                     w_any_overlap;
    logic                     w_hit;
    logic                     w_stall;
    logic [WD_W-1:0]          w_fwd_data;
`ifdef STORE_FWD_EN
    logic [PTR_W-1:0]         w_match_idx;
    logic                     w_fwd_ok;
`endif

    // Walk live entries oldest to youngest; the last overlapping one seen is the youngest.
    always_comb begin
        w_ld_len      = size_bytes(ld_size_i);
        w_any_overlap = 1'b0;
`ifdef STORE_FWD_EN
        w_match_idx   = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < r_count) &&
                ranges_overlap(r_addr[r_head + PTR_W'(k)], size_bytes(r_size[r_head + PTR_W'(k)]),
                               ld_addr_i, w_ld_len)) begin
                w_any_overlap = 1'b1;
`ifdef STORE_FWD_EN
                w_match_idx   = r_head + PTR_W'(k);
`endif
            end
        end
    end

`ifdef STORE_FWD_EN
    always_comb begin
        w_fwd_ok   = w_any_overlap && (r_addr[w_match_idx] == ld_addr_i) &&
                     (size_bytes(r_size[w_match_idx]) >= w_ld_len);
        w_hit      = ld_valid_i && w_fwd_ok;
        w_stall    = ld_valid_i && w_any_overlap && !w_fwd_ok;
        w_fwd_data = w_hit ? extend(r_data[w_match_idx], ld_size_i) : '0;
    end
`else
    always_comb begin
        w_hit      = 1'b0;
        w_stall    = ld_valid_i && w_any_overlap;
        w_fwd_data = '0;
    end
`endif

    assign w_load_own = ld_valid_i && !w_stall;
    assign w_drain    = !w_load_own && (r_count != '0);
    assign w_enq      = st_valid_i && r_ready;

    always_comb begin
        case ({w_enq, w_drain})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_comb begin
        mem_a_o     = ld_addr_i;
        mem_load3_o = ld_size_i;
        mem_wd_o    = '0;
        mem_wen_o   = 1'b0;
        if (w_drain) begin
            mem_a_o     = r_addr[r_head];
            mem_load3_o = r_size[r_head];
            mem_wd_o    = r_data[r_head];
            mem_wen_o   = 1'b1;
        end
    end

    // NOTE: ready is its own register so it can sit low during reset and rise on the first edge after.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ready <= 1'b0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_drain) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= w_count_next;
            r_ready <= (w_count_next < CNT_W'(DEPTH));
        end
    end

    // NOTE: entry storage is deliberately not reset; r_count alone decides which slots are live.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_addr[r_tail] <= st_addr_i;
            r_data[r_tail] <= st_data_i;
            r_size[r_tail] <= store_size(st_size_i);
        end
    end

    assign st_ready_o  = r_ready;
    assign count_o     = r_count;
    assign fwd_hit_o   = w_hit;
    assign fwd_stall_o = w_stall;
    assign fwd_data_o  = w_fwd_data;

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (default parameters: 8-bit address, 32-bit data, depth 4).
// Expectations follow STORE_FWD_EN when the bench is built with it defined.

module tb_store_buffer;
    import store_buffer_pkg::*;

`ifdef STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk_i;
    logic        rst_i;
    logic        st_valid_i;
    logic [7:0]  st_addr_i;
    logic [31:0] st_data_i;
    load3_t      st_size_i;
    logic        st_ready_o;
    logic        ld_valid_i;
    logic [7:0]  ld_addr_i;
    load3_t      ld_size_i;
    logic        fwd_hit_o;
    logic [31:0] fwd_data_o;
    logic        fwd_stall_o;
    logic [7:0]  mem_a_o;
    logic [31:0] mem_wd_o;
    load3_t      mem_load3_o;
    logic        mem_wen_o;
    logic [2:0]  count_o;

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] a_data [4] = '{32'hA0A0_0000, 32'hA0A0_0011, 32'hA0A0_0022, 32'hA0A0_0033};
    logic [31:0] b_data [6] = '{32'hB000_0000, 32'hB111_1111, 32'hB222_2222,
                                32'hB333_3333, 32'hB444_4444, 32'hB555_5555};
    logic [7:0]  b_tail_a [3] = '{8'h2C, 8'h30, 8'h34};
    logic [31:0] b_tail_d [3] = '{32'hB333_3333, 32'hB444_4444, 32'hB555_5555};

    store_buffer #(
        .ADDRESS_WIDTH(8),
        .DATA_WIDTH   (8),
        .DEPTH        (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .st_valid_i  (st_valid_i),
        .st_addr_i   (st_addr_i),
        .st_data_i   (st_data_i),
        .st_size_i   (st_size_i),
        .st_ready_o  (st_ready_o),
        .ld_valid_i  (ld_valid_i),
        .ld_addr_i   (ld_addr_i),
        .ld_size_i   (ld_size_i),
        .fwd_hit_o   (fwd_hit_o),
        .fwd_data_o  (fwd_data_o),
        .fwd_stall_o (fwd_stall_o),
        .mem_a_o     (mem_a_o),
        .mem_wd_o    (mem_wd_o),
        .mem_load3_o (mem_load3_o),
        .mem_wen_o   (mem_wen_o),
        .count_o     (count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic put_store(input logic [7:0] a, input logic [31:0] d, input load3_t s);
        st_valid_i = 1'b1;
        st_addr_i  = a;
        st_data_i  = d;
        st_size_i  = s;
    endtask

    task automatic no_store();
        st_valid_i = 1'b0;
        st_addr_i  = 8'h00;
        st_data_i  = 32'h0;
        st_size_i  = WORD;
    endtask

    task automatic put_load(input logic [7:0] a, input load3_t s);
        ld_valid_i = 1'b1;
        ld_addr_i  = a;
        ld_size_i  = s;
    endtask

    task automatic no_load();
        ld_valid_i = 1'b0;
        ld_addr_i  = 8'h00;
        ld_size_i  = WORD;
    endtask

    initial begin
        // ---- reset state
        rst_i = 1'b1;
        no_store();
        no_load();
        tick();
        tick();
        check("rst_count", 32'(count_o), 0);
        check("rst_ready", 32'(st_ready_o), 0);
        check("rst_wen", 32'(mem_wen_o), 0);
        check("rst_hit", 32'(fwd_hit_o), 0);
        check("rst_stall", 32'(fwd_stall_o), 0);
        check("rst_fdata", fwd_data_o, 0);
        rst_i = 1'b0;
        tick();
        check("ready_after_rst", 32'(st_ready_o), 1);

        // ---- fill with loads owning the port, then drain in FIFO order
        put_load(8'h80, WORD);
        for (int i = 0; i < 4; i++) begin
            put_store(8'(4 * i), a_data[i], WORD);
            tick();
        end
        check("fill_count", 32'(count_o), 4);
        check("fill_ready", 32'(st_ready_o), 0);
        check("fill_wen", 32'(mem_wen_o), 0);
        check("fill_mem_a", 32'(mem_a_o), 32'h80);
        put_store(8'h40, 32'hDEAD_BEEF, WORD);
        tick();
        check("full_ignore_count", 32'(count_o), 4);
        no_store();
        no_load();
        settle();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d_wen", i), 32'(mem_wen_o), 1);
            check($sformatf("drain%0d_a", i), 32'(mem_a_o), 32'(4 * i));
            check($sformatf("drain%0d_wd", i), mem_wd_o, a_data[i]);
            check($sformatf("drain%0d_count", i), 32'(count_o), 32'(4 - i));
            tick();
        end
        check("drained_count", 32'(count_o), 0);
        check("drained_wen", 32'(mem_wen_o), 0);
        check("drained_ready", 32'(st_ready_o), 1);

        // ---- full buffer with a store waiting: drain frees a slot, then enqueue and drain coincide
        put_load(8'h80, WORD);
        for (int i = 0; i < 4; i++) begin
            put_store(8'h20 + 8'(4 * i), b_data[i], WORD);
            tick();
        end
        no_load();
        put_store(8'h30, b_data[4], WORD);
        settle();
        check("sat_count0", 32'(count_o), 4);
        check("sat_ready0", 32'(st_ready_o), 0);
        check("sat_a0", 32'(mem_a_o), 32'h20);
        tick();
        check("sat_count1", 32'(count_o), 3);
        check("sat_ready1", 32'(st_ready_o), 1);
        check("sat_a1", 32'(mem_a_o), 32'h24);
        tick();
        check("sat_count2", 32'(count_o), 3);
        check("sat_a2", 32'(mem_a_o), 32'h28);
        put_store(8'h34, b_data[5], WORD);
        tick();
        check("sat_count3", 32'(count_o), 3);
        no_store();
        settle();
        for (int j = 0; j < 3; j++) begin
            check($sformatf("sat_tail%0d_a", j), 32'(mem_a_o), 32'(b_tail_a[j]));
            check($sformatf("sat_tail%0d_wd", j), mem_wd_o, b_tail_d[j]);
            tick();
        end
        check("sat_empty", 32'(count_o), 0);

        // ---- partial overlap stalls the load until the entry drains
        put_load(8'h80, WORD);
        put_store(8'h11, 32'h0000_00AB, BYTE);
        tick();
        no_store();
        put_load(8'h10, WORD);
        settle();
        check("part_count", 32'(count_o), 1);
        check("part_stall", 32'(fwd_stall_o), 1);
        check("part_hit", 32'(fwd_hit_o), 0);
        check("part_wen", 32'(mem_wen_o), 1);
        check("part_a", 32'(mem_a_o), 32'h11);
        check("part_wd", mem_wd_o, 32'h0000_00AB);
        check("part_size", 32'(mem_load3_o), 32'(BYTE));
        tick();
        check("part_after_count", 32'(count_o), 0);
        check("part_after_stall", 32'(fwd_stall_o), 0);
        check("part_after_wen", 32'(mem_wen_o), 0);
        check("part_after_a", 32'(mem_a_o), 32'h10);
        check("part_after_size", 32'(mem_load3_o), 32'(WORD));

        // ---- unsigned store sizes are recorded as their signed counterparts
        put_load(8'h80, WORD);
        put_store(8'h50, 32'h0000_1234, U_HALF);
        tick();
        no_store();
        no_load();
        settle();
        check("uhalf_a", 32'(mem_a_o), 32'h50);
        check("uhalf_size", 32'(mem_load3_o), 32'(HALF));
        tick();
        check("uhalf_empty", 32'(count_o), 0);

        // ---- forwarding from an exact-start entry, then youngest-entry selection
        put_load(8'h80, WORD);
        put_store(8'h10, 32'h8000_00F0, WORD);
        tick();
        no_store();
        put_load(8'h10, BYTE);
        settle();
        check("fw_byte_hit", 32'(fwd_hit_o), FWD ? 1 : 0);
        check("fw_byte_data", fwd_data_o, FWD ? 32'hFFFF_FFF0 : 32'h0);
        check("fw_byte_stall", 32'(fwd_stall_o), FWD ? 0 : 1);
        check("fw_byte_wen", 32'(mem_wen_o), FWD ? 0 : 1);
        put_load(8'h10, U_BYTE);
        settle();
        check("fw_ubyte_data", fwd_data_o, FWD ? 32'h0000_00F0 : 32'h0);
        put_load(8'h10, HALF);
        settle();
        check("fw_half_data", fwd_data_o, FWD ? 32'h0000_00F0 : 32'h0);
        put_load(8'h10, WORD);
        settle();
        check("fw_word_data", fwd_data_o, FWD ? 32'h8000_00F0 : 32'h0);
        put_load(8'h11, BYTE);
        settle();
        check("fw_offset_stall", 32'(fwd_stall_o), 1);
        check("fw_offset_hit", 32'(fwd_hit_o), 0);
        put_load(8'h80, WORD);
        put_store(8'h10, 32'h0000_0085, BYTE);
        tick();
        no_store();
        put_load(8'h10, BYTE);
        settle();
        check("young_count", 32'(count_o), 2);
        check("young_byte_hit", 32'(fwd_hit_o), FWD ? 1 : 0);
        check("young_byte_data", fwd_data_o, FWD ? 32'hFFFF_FF85 : 32'h0);
        check("young_byte_stall", 32'(fwd_stall_o), FWD ? 0 : 1);
        put_load(8'h10, WORD);
        settle();
        check("young_word_stall", 32'(fwd_stall_o), 1);
        check("young_word_hit", 32'(fwd_hit_o), 0);
        no_load();
        settle();
        check("young_drain0_wd", mem_wd_o, 32'h8000_00F0);
        check("young_drain0_size", 32'(mem_load3_o), 32'(WORD));
        tick();
        check("young_drain1_wd", mem_wd_o, 32'h0000_0085);
        check("young_drain1_size", 32'(mem_load3_o), 32'(BYTE));
        tick();
        check("young_empty", 32'(count_o), 0);

        // ---- overlap detected through address wrap
        put_load(8'h80, WORD);
        put_store(8'hFF, 32'h0000_BEEF, HALF);
        tick();
        no_store();
        put_load(8'h00, BYTE);
        settle();
        check("wrap_stall", 32'(fwd_stall_o), 1);
        check("wrap_hit", 32'(fwd_hit_o), 0);
        check("wrap_wen", 32'(mem_wen_o), 1);
        check("wrap_a", 32'(mem_a_o), 32'hFF);
        put_load(8'hFF, BYTE);
        settle();
        check("wrap_ff_hit", 32'(fwd_hit_o), FWD ? 1 : 0);
        check("wrap_ff_data", fwd_data_o, FWD ? 32'hFFFF_FFEF : 32'h0);
        check("wrap_ff_stall", 32'(fwd_stall_o), FWD ? 0 : 1);
        put_load(8'hFF, HALF);
        settle();
        check("wrap_ffh_data", fwd_data_o, FWD ? 32'hFFFF_BEEF : 32'h0);
        put_load(8'h01, BYTE);
        settle();
        check("wrap_01_stall", 32'(fwd_stall_o), 0);
        check("wrap_01_wen", 32'(mem_wen_o), 0);
        check("wrap_01_a", 32'(mem_a_o), 32'h01);
        put_load(8'hFE, BYTE);
        settle();
        check("wrap_fe_stall", 32'(fwd_stall_o), 0);
        no_load();
        tick();
        check("wrap_empty", 32'(count_o), 0);

        // ---- reset with entries pending discards them
        put_load(8'h80, WORD);
        for (int i = 0; i < 3; i++) begin
            put_store(8'h60 + 8'(4 * i), 32'hC000_0000 + 32'(i), WORD);
            tick();
        end
        no_store();
        settle();
        check("mid_count", 32'(count_o), 3);
        no_load();
        rst_i = 1'b1;
        settle();
        check("mid_rst_count", 32'(count_o), 0);
        check("mid_rst_wen", 32'(mem_wen_o), 0);
        check("mid_rst_ready", 32'(st_ready_o), 0);
        tick();
        check("mid_rst_wen_edge", 32'(mem_wen_o), 0);
        rst_i = 1'b0;
        settle();
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_rst%0d_wen", i), 32'(mem_wen_o), 0);
            check($sformatf("post_rst%0d_count", i), 32'(count_o), 0);
        end
        check("post_rst_ready", 32'(st_ready_o), 1);
        put_store(8'h70, 32'h0000_0055, WORD);
        tick();
        no_store();
        settle();
        check("post_rst_store_count", 32'(count_o), 1);
        check("post_rst_store_wen", 32'(mem_wen_o), 1);
        check("post_rst_store_a", 32'(mem_a_o), 32'h70);
        check("post_rst_store_wd", mem_wd_o, 32'h0000_0055);
        tick();
        check("final_empty", 32'(count_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
